// File: rtl/instruction_loader_if.sv
// Byte-stream and memory-write bundle between an instruction source and the loader.
// The master drives commands and bytes; the slave (the loader) drives writes and status.
interface instruction_loader_if;
  logic        Start;
  logic [63:0] Base_Address;
  logic [7:0]  Word_Count;
  logic [7:0]  Byte_In;
  logic        Byte_Valid;
  logic        Byte_Ready;
  logic [63:0] Wr_Address;
  logic [31:0] Wr_Data;
  logic        Wr_En;
  logic        Busy;
  logic        Done;
  logic        Error;

  modport master (
    output Start, Base_Address, Word_Count, Byte_In, Byte_Valid,
    input  Byte_Ready, Wr_Address, Wr_Data, Wr_En, Busy, Done, Error
  );

  modport slave (
    input  Start, Base_Address, Word_Count, Byte_In, Byte_Valid,
    output Byte_Ready, Wr_Address, Wr_Data, Wr_En, Busy, Done, Error
  );
endinterface

// File: rtl/instruction_loader.sv
// Assembles a little-endian byte stream into 32-bit words and writes them to
// instruction memory starting at a bounds-checked, word-aligned base address.
module instruction_loader #(
  parameter int unsigned MEM_BYTES = 96
) (
  input logic                 clk,
  input logic                 reset,
  instruction_loader_if.slave bus
);
  localparam int unsigned ADDR_W = 64;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 8;
  localparam int unsigned CHK_W  = ADDR_W + 2;

  typedef enum logic [1:0] {IDLE, COLLECT, WRITE, FINISH} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [CNT_W-1:0]    word_cnt_q, word_cnt_d;
  logic [1:0]          byte_cnt_q, byte_cnt_d;
  logic [DATA_W-1:0]   asm_q, asm_d;
  logic                byte_ready_q, byte_ready_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0]   wr_data_q, wr_data_d;
  logic                wr_en_q, wr_en_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                error_q, error_d;

  logic [CHK_W-1:0]    end_addr_c;
  logic                illegal_c;
  logic                last_word_c;

  // End address is formed two bits wider than the bus so a huge base cannot wrap past the check.
  assign end_addr_c  = CHK_W'(bus.Base_Address) + (CHK_W'(bus.Word_Count) << 2);
  assign illegal_c   = (bus.Base_Address[1:0] != 2'b00) || (end_addr_c > CHK_W'(MEM_BYTES));
  assign last_word_c = ((CNT_W + 1)'(word_cnt_q) + (CNT_W + 1)'(1)) == (CNT_W + 1)'(count_q);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= IDLE;
      base_q       <= '0;
      count_q      <= '0;
      word_cnt_q   <= '0;
      byte_cnt_q   <= '0;
      asm_q        <= '0;
      byte_ready_q <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      wr_en_q      <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      base_q       <= base_d;
      count_q      <= count_d;
      word_cnt_q   <= word_cnt_d;
      byte_cnt_q   <= byte_cnt_d;
      asm_q        <= asm_d;
      byte_ready_q <= byte_ready_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      wr_en_q      <= wr_en_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      error_q      <= error_d;
    end
  end

  // Next state; write strobe and write payload are set up on the 4th byte so they appear in WRITE.
  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    count_d    = count_q;
    word_cnt_d = word_cnt_q;
    byte_cnt_d = byte_cnt_q;
    asm_d      = asm_q;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    wr_en_d    = 1'b0;
    error_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.Start) begin
          if (illegal_c) begin
            error_d = 1'b1;
          end else begin
            base_d     = bus.Base_Address;
            count_d    = bus.Word_Count;
            word_cnt_d = '0;
            byte_cnt_d = '0;
            asm_d      = '0;
            state_d    = (bus.Word_Count == '0) ? FINISH : COLLECT;
          end
        end
      end
      COLLECT: begin
        if (bus.Byte_Valid) begin
          asm_d[{byte_cnt_q, 3'b000} +: 8] = bus.Byte_In;
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            state_d   = WRITE;
            wr_en_d   = 1'b1;
            wr_data_d = asm_d;
            wr_addr_d = base_q + ADDR_W'({word_cnt_q, 2'b00});
          end
        end
      end
      WRITE: begin
        word_cnt_d = word_cnt_q + CNT_W'(1);
        state_d    = last_word_c ? FINISH : COLLECT;
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    byte_ready_d = (state_d == COLLECT);
    busy_d       = (state_d != IDLE);
    done_d       = (state_d == FINISH);
  end

  assign bus.Byte_Ready = byte_ready_q;
  assign bus.Wr_Address = wr_addr_q;
  assign bus.Wr_Data    = wr_data_q;
  assign bus.Wr_En      = wr_en_q;
  assign bus.Busy       = busy_q;
  assign bus.Done       = done_q;
  assign bus.Error      = error_q;
endmodule

// File: tb/tb_instruction_loader.sv
// Self-checking bench for instruction_loader: command vector table, scoreboarded
// memory writes, and hand-written sequences for timing, reset and busy corners.
module tb_instruction_loader;
  logic clk;
  logic reset;

  instruction_loader_if bus();

  instruction_loader #(.MEM_BYTES(96)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] addr;
    logic [31:0] data;
  } exp_t;

  typedef struct {
    logic [63:0] base;
    logic [7:0]  cnt;
    bit          err;
    bit          gaps;
  } vec_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   passed = 0;
  int   err_seen = 0;
  int   done_seen = 0;
  int   exp_err_total = 0;
  int   exp_done_total = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Scoreboard: every write strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (bus.Error) err_seen++;
    if (bus.Done)  done_seen++;
    if (bus.Wr_En) begin
      chk("sb_write_expected", 64'(sb_q.size() != 0), 64'd1);
      if (sb_q.size() != 0) begin
        exp_t e;
        e = sb_q.pop_front();
        chk("sb_wr_address", bus.Wr_Address, e.addr);
        chk("sb_wr_data", 64'(bus.Wr_Data), 64'(e.data));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_cmd(input logic [63:0] base, input logic [7:0] cnt);
    bus.Byte_Valid   = 1'b0;
    bus.Start        = 1'b1;
    bus.Base_Address = base;
    bus.Word_Count   = cnt;
    step();
    bus.Start        = 1'b0;
    bus.Base_Address = 64'hDEAD_BEEF_DEAD_BEEF;
    bus.Word_Count   = 8'hEE;
  endtask

  task automatic put_byte(input logic [7:0] b, output bit ok);
    int   t;
    logic acc;
    t  = 0;
    ok = 1'b0;
    bus.Byte_In    = b;
    bus.Byte_Valid = 1'b1;
    while (!ok && t < 200) begin
      @(negedge clk);
      acc = bus.Byte_Ready;
      step();
      t++;
      if (acc === 1'b1) ok = 1'b1;
    end
  endtask

  task automatic send_word(input logic [63:0] addr, input logic [31:0] w, input bit gaps);
    bit ok;
    for (int k = 0; k < 4; k++) begin
      if (gaps) begin
        int n;
        n = $urandom_range(0, 3);
        if (n != 0) begin
          bus.Byte_Valid = 1'b0;
          bus.Byte_In    = 8'hFF;
          repeat (n) step();
        end
      end
      put_byte(w[8*k +: 8], ok);
      chk("byte_accept", 64'(ok), 64'd1);
    end
    bus.Byte_Valid = 1'b0;
    sb_q.push_back('{addr: addr, data: w});
  endtask

  task automatic wait_done();
    int t;
    bit seen;
    t    = 0;
    seen = 1'b0;
    while (!seen && t < 100) begin
      @(negedge clk);
      seen = bus.Done;
      t++;
    end
    chk("done_seen", 64'(seen), 64'd1);
    step();
  endtask

  vec_t vecs[11];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit ok;
    vecs[0]  = '{base: 64'd4,  cnt: 8'd1,  err: 1'b0, gaps: 1'b1};
    vecs[1]  = '{base: 64'd2,  cnt: 8'd1,  err: 1'b1, gaps: 1'b0};
    vecs[2]  = '{base: 64'd92, cnt: 8'd2,  err: 1'b1, gaps: 1'b0};
    vecs[3]  = '{base: 64'd92, cnt: 8'd1,  err: 1'b0, gaps: 1'b1};
    vecs[4]  = '{base: 64'd96, cnt: 8'd0,  err: 1'b0, gaps: 1'b0};
    vecs[5]  = '{base: 64'd97, cnt: 8'd0,  err: 1'b1, gaps: 1'b0};
    vecs[6]  = '{base: 64'd0,  cnt: 8'd25, err: 1'b1, gaps: 1'b0};
    vecs[7]  = '{base: 64'hFFFF_FFFF_FFFF_FFFC, cnt: 8'd1, err: 1'b1, gaps: 1'b0};
    vecs[8]  = '{base: 64'd0,  cnt: 8'd0,  err: 1'b0, gaps: 1'b0};
    vecs[9]  = '{base: 64'd0,  cnt: 8'd24, err: 1'b0, gaps: 1'b1};
    vecs[10] = '{base: 64'd8,  cnt: 8'd3,  err: 1'b0, gaps: 1'b0};

    reset = 1'b0;
    bus.Start = 1'b0;
    bus.Base_Address = '0;
    bus.Word_Count = '0;
    bus.Byte_In = 8'h00;
    bus.Byte_Valid = 1'b0;
    repeat (3) step();
    @(negedge clk);
    chk("rst_busy", 64'(bus.Busy), 64'd0);
    chk("rst_byte_ready", 64'(bus.Byte_Ready), 64'd0);
    chk("rst_wr_en", 64'(bus.Wr_En), 64'd0);
    chk("rst_done", 64'(bus.Done), 64'd0);
    chk("rst_error", 64'(bus.Error), 64'd0);
    chk("rst_wr_address", bus.Wr_Address, 64'd0);
    chk("rst_wr_data", 64'(bus.Wr_Data), 64'd0);
    step();
    reset = 1'b1;
    step();

    // Bytes offered while idle must not leak into the next word.
    bus.Byte_In = 8'hFF;
    bus.Byte_Valid = 1'b1;
    repeat (3) step();

    // Back-to-back bytes: write the cycle after the 4th byte, Done the cycle after that.
    start_cmd(64'd4, 8'd1);
    send_word(64'd4, 32'h04000E63, 1'b0);
    exp_done_total++;
    @(negedge clk);
    chk("seq_wr_en", 64'(bus.Wr_En), 64'd1);
    chk("seq_wr_address", bus.Wr_Address, 64'd4);
    chk("seq_wr_data", 64'(bus.Wr_Data), 64'h04000E63);
    chk("seq_done_early", 64'(bus.Done), 64'd0);
    @(negedge clk);
    chk("seq_done", 64'(bus.Done), 64'd1);
    chk("seq_wr_en_drop", 64'(bus.Wr_En), 64'd0);
    @(negedge clk);
    chk("seq_idle", 64'(bus.Busy), 64'd0);
    chk("seq_hold_address", bus.Wr_Address, 64'd4);
    chk("seq_hold_data", 64'(bus.Wr_Data), 64'h04000E63);
    step();

    for (int i = 0; i < 11; i++) begin
      start_cmd(vecs[i].base, vecs[i].cnt);
      if (vecs[i].err) begin
        exp_err_total++;
        @(negedge clk);
        chk("vec_error", 64'(bus.Error), 64'd1);
        chk("vec_err_busy", 64'(bus.Busy), 64'd0);
        chk("vec_err_ready", 64'(bus.Byte_Ready), 64'd0);
        @(negedge clk);
        chk("vec_error_pulse", 64'(bus.Error), 64'd0);
        step();
      end else if (vecs[i].cnt == 8'd0) begin
        exp_done_total++;
        @(negedge clk);
        chk("vec_zero_done", 64'(bus.Done), 64'd1);
        chk("vec_zero_ready", 64'(bus.Byte_Ready), 64'd0);
        chk("vec_zero_error", 64'(bus.Error), 64'd0);
        @(negedge clk);
        chk("vec_zero_idle", 64'(bus.Busy), 64'd0);
        step();
      end else begin
        exp_done_total++;
        @(negedge clk);
        chk("vec_ok_error", 64'(bus.Error), 64'd0);
        chk("vec_ok_ready", 64'(bus.Byte_Ready), 64'd1);
        step();
        for (int w = 0; w < int'(vecs[i].cnt); w++)
          send_word(vecs[i].base + 64'(4 * w), $urandom, vecs[i].gaps);
        wait_done();
        chk("vec_sb_drained", 64'(sb_q.size()), 64'd0);
      end
    end

    // Reset partway through a word drops the partial bytes; the next load starts clean.
    start_cmd(64'd0, 8'd2);
    put_byte(8'h11, ok);
    chk("rst_mid_byte0", 64'(ok), 64'd1);
    put_byte(8'h22, ok);
    chk("rst_mid_byte1", 64'(ok), 64'd1);
    bus.Byte_Valid = 1'b0;
    reset = 1'b0;
    step();
    @(negedge clk);
    chk("rst_mid_busy", 64'(bus.Busy), 64'd0);
    chk("rst_mid_ready", 64'(bus.Byte_Ready), 64'd0);
    chk("rst_mid_wr_address", bus.Wr_Address, 64'd0);
    chk("rst_mid_wr_data", 64'(bus.Wr_Data), 64'd0);
    step();
    reset = 1'b1;
    step();
    start_cmd(64'd8, 8'd1);
    send_word(64'd8, 32'hA5B6C7D8, 1'b1);
    exp_done_total++;
    wait_done();
    chk("rst_new_address", bus.Wr_Address, 64'd8);
    chk("rst_new_data", 64'(bus.Wr_Data), 64'hA5B6C7D8);

    // A Start while busy (even an illegal one) is ignored without an Error pulse.
    start_cmd(64'd16, 8'd2);
    send_word(64'd16, 32'h1234_5678, 1'b1);
    start_cmd(64'd2, 8'd1);
    chk("busy_start_busy", 64'(bus.Busy), 64'd1);
    start_cmd(64'd40, 8'd1);
    send_word(64'd20, 32'h9ABC_DEF0, 1'b0);
    exp_done_total++;
    wait_done();
    repeat (3) step();

    chk("final_sb_empty", 64'(sb_q.size()), 64'd0);
    chk("final_error_count", 64'(err_seen), 64'(exp_err_total));
    chk("final_done_count", 64'(done_seen), 64'(exp_done_total));
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
